// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// One mem_cmd_*/mem_rsp_* link between a bus master and a bus slave.
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready are
// both high. The master holds every cmd_* field stable while
// cmd_valid && !cmd_ready. rsp_ready is a single-cycle pulse qualifying
// rsp_rdata. It carries no backpressure, so the master must take it.
//
// Signals:
//   cmd_valid  master -> slave  command request
//   cmd_ready  slave  -> master command accepted this cycle
//   cmd_wr     master -> slave  1 = write, 0 = read
//   cmd_instr  master -> slave  instruction fetch flag
//   cmd_addr   master -> slave  byte address (32)
//   cmd_wdata  master -> slave  write data (32)
//   cmd_be     master -> slave  byte enables (4)
//   rsp_ready  slave  -> master read data valid pulse
//   rsp_rdata  slave  -> master read data (32)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic        cmd_instr;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_be;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;

   modport master (
      output cmd_valid, cmd_wr, cmd_instr, cmd_addr, cmd_wdata, cmd_be,
      input  cmd_ready, rsp_ready, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_wr, cmd_instr, cmd_addr, cmd_wdata, cmd_be,
      output cmd_ready, rsp_ready, rsp_rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Two masters (m0 = CPU wrapper, m1 = DMA/debug loader) share one slave
// (the address decoder). Commands are granted round-robin. Read responses come
// back from the slave strictly in order and are routed to the issuing master
// through a small in-order ID FIFO.
//
// Ports:
//   clk                 single clock
//   reset               synchronous, active-high reset
//   m0, m1              master links (slave side of mem_bus_arbiter_if)
//   s                   slave link (master side of mem_bus_arbiter_if)
//   err_unexpected_rsp  sticky: a slave response arrived with no read in flight
//   o_dbg_count         reads currently outstanding
//   o_dbg_last_grant    master that won the last accepted command
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk,
   input  logic                                   reset,
   mem_bus_arbiter_if.slave                       m0,
   mem_bus_arbiter_if.slave                       m1,
   mem_bus_arbiter_if.master                      s,
   output logic                                   err_unexpected_rsp,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_dbg_count,
   output logic                                   o_dbg_last_grant
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

   logic                       r_last_grant;
   logic [CW-1:0]              r_count;
   logic [MAX_OUTSTANDING-1:0] r_fifo;      // one ID bit per in-flight read
   logic [PW-1:0]              r_wr_ptr;
   logic [PW-1:0]              r_rd_ptr;
   logic                       r_err;

   logic w_grant;
   logic w_g_valid;
   logic w_g_wr;
   logic w_block;
   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_head_id;

   // Pointers wrap modulo MAX_OUTSTANDING, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Round-robin: on contention the master that did not win last time goes.
   always_comb begin
      w_grant = 1'b0;
      if (m0.cmd_valid && m1.cmd_valid) w_grant = ~r_last_grant;
      else if (m1.cmd_valid)            w_grant = 1'b1;
   end

   assign w_g_valid = w_grant ? m1.cmd_valid : m0.cmd_valid;
   assign w_g_wr    = w_grant ? m1.cmd_wr    : m0.cmd_wr;

   // Only reads consume a FIFO slot, so only reads are held back when full.
   // Uses the registered count: a response in the same cycle does not help.
   assign w_block = !w_g_wr && (r_count == CNT_MAX);

   assign s.cmd_valid = w_g_valid && !w_block && !reset;
   assign s.cmd_wr    = w_g_wr;
   assign s.cmd_instr = w_grant ? m1.cmd_instr : m0.cmd_instr;
   assign s.cmd_addr  = w_grant ? m1.cmd_addr  : m0.cmd_addr;
   assign s.cmd_wdata = w_grant ? m1.cmd_wdata : m0.cmd_wdata;
   assign s.cmd_be    = w_grant ? m1.cmd_be    : m0.cmd_be;

   assign w_accept     = s.cmd_valid && s.cmd_ready;
   assign m0.cmd_ready = w_accept && !w_grant;
   assign m1.cmd_ready = w_accept &&  w_grant;

   assign w_push    = w_accept && !w_g_wr;
   // A response with nothing outstanding is dropped rather than popped.
   assign w_pop     = s.rsp_ready && (r_count != '0) && !reset;
   assign w_head_id = r_fifo[r_rd_ptr];

   assign m0.rsp_ready = w_pop && !w_head_id;
   assign m1.rsp_ready = w_pop &&  w_head_id;
   assign m0.rsp_rdata = s.rsp_rdata;
   assign m1.rsp_rdata = s.rsp_rdata;

   // ID storage needs no reset: entries are only read behind a valid count.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= w_grant;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_count      <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_err        <= 1'b0;
      end else begin
         if (w_accept) r_last_grant <= w_grant;
         if (w_push)   r_wr_ptr     <= ptr_inc(r_wr_ptr);
         if (w_pop)    r_rd_ptr     <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (s.rsp_ready && (r_count == '0)) r_err <= 1'b1;
      end
   end

   assign err_unexpected_rsp = r_err;
   assign o_dbg_count        = r_count;
   assign o_dbg_last_grant   = r_last_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Cycle table of {inputs, expected outputs} applied in order (state carries
// from row to row), followed by a hand-written outstanding-limit sequence.
// Inputs change on the falling edge and outputs are checked 2 ns later.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int MAXO = 4;
   localparam int CW   = $clog2(MAXO + 1);

   localparam logic [31:0] M0_WDATA = 32'h1111_1111;
   localparam logic [31:0] M1_WDATA = 32'h2222_2222;
   localparam logic [3:0]  M0_BE    = 4'h3;
   localparam logic [3:0]  M1_BE    = 4'hC;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_bus_arbiter_if m0_if ();
   mem_bus_arbiter_if m1_if ();
   mem_bus_arbiter_if s_if ();

   logic          err;
   logic [CW-1:0] dbg_count;
   logic          dbg_last_grant;

   mem_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk                (clk),
      .reset              (reset),
      .m0                 (m0_if),
      .m1                 (m1_if),
      .s                  (s_if),
      .err_unexpected_rsp (err),
      .o_dbg_count        (dbg_count),
      .o_dbg_last_grant   (dbg_last_grant)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        rst;
      logic        m0_v;
      logic        m0_wr;
      logic [31:0] m0_a;
      logic        m1_v;
      logic        m1_wr;
      logic [31:0] m1_a;
      logic        s_rdy;
      logic        s_rsp;
      logic [31:0] s_rd;
      logic        e_m0_rdy;
      logic        e_m1_rdy;
      logic        e_s_v;
      logic        e_gnt;
      logic        e_m0_rsp;
      logic        e_m1_rsp;
      logic        e_err;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vq[$];

   // ---------------- driver tasks ----------------
   task automatic drive(input logic rst, input logic m0v, input logic m0wr,
                        input logic [31:0] m0a, input logic m1v, input logic m1wr,
                        input logic [31:0] m1a, input logic srdy, input logic srsp,
                        input logic [31:0] srd);
      reset              = rst;
      m0_if.cmd_valid    = m0v;
      m0_if.cmd_wr       = m0wr;
      m0_if.cmd_addr     = m0a;
      m0_if.cmd_wdata    = M0_WDATA;
      m0_if.cmd_be       = M0_BE;
      m0_if.cmd_instr    = 1'b1;
      m1_if.cmd_valid    = m1v;
      m1_if.cmd_wr       = m1wr;
      m1_if.cmd_addr     = m1a;
      m1_if.cmd_wdata    = M1_WDATA;
      m1_if.cmd_be       = M1_BE;
      m1_if.cmd_instr    = 1'b0;
      s_if.cmd_ready     = srdy;
      s_if.rsp_ready     = srsp;
      s_if.rsp_rdata     = srd;
   endtask

   task automatic add(input logic rst, input logic m0v, input logic m0wr,
                      input logic [31:0] m0a, input logic m1v, input logic m1wr,
                      input logic [31:0] m1a, input logic srdy, input logic srsp,
                      input logic [31:0] srd, input logic em0r, input logic em1r,
                      input logic esv, input logic egnt, input logic em0rsp,
                      input logic em1rsp, input logic eerr, input logic [2:0] ecnt);
      vec_t t;
      t = '{rst, m0v, m0wr, m0a, m1v, m1wr, m1a, srdy, srsp, srd,
            em0r, em1r, esv, egnt, em0rsp, em1rsp, eerr, ecnt};
      vq.push_back(t);
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_vec(input int i, input vec_t v);
      string p;
      p = $sformatf("v%0d", i);
      chk({p, " m0_cmd_ready"}, 32'(m0_if.cmd_ready), 32'(v.e_m0_rdy));
      chk({p, " m1_cmd_ready"}, 32'(m1_if.cmd_ready), 32'(v.e_m1_rdy));
      chk({p, " s_cmd_valid"},  32'(s_if.cmd_valid),  32'(v.e_s_v));
      chk({p, " m0_rsp_ready"}, 32'(m0_if.rsp_ready), 32'(v.e_m0_rsp));
      chk({p, " m1_rsp_ready"}, 32'(m1_if.rsp_ready), 32'(v.e_m1_rsp));
      chk({p, " err"},          32'(err),             32'(v.e_err));
      chk({p, " count"},        32'(dbg_count),       32'(v.e_cnt));
      if (v.e_s_v) begin
         chk({p, " s_cmd_addr"},  s_if.cmd_addr,         v.e_gnt ? v.m1_a : v.m0_a);
         chk({p, " s_cmd_wr"},    32'(s_if.cmd_wr),      32'(v.e_gnt ? v.m1_wr : v.m0_wr));
         chk({p, " s_cmd_wdata"}, s_if.cmd_wdata,        v.e_gnt ? M1_WDATA : M0_WDATA);
         chk({p, " s_cmd_be"},    32'(s_if.cmd_be),      32'(v.e_gnt ? M1_BE : M0_BE));
         chk({p, " s_cmd_instr"}, 32'(s_if.cmd_instr),   32'(!v.e_gnt));
      end
      if (v.e_m0_rsp) chk({p, " m0_rsp_rdata"}, m0_if.rsp_rdata, v.s_rd);
      if (v.e_m1_rsp) chk({p, " m1_rsp_rdata"}, m1_if.rsp_rdata, v.s_rd);
   endtask

   // ---------------- test ----------------
   initial begin
      drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);

      // rst m0v wr  m0a           m1v wr  m1a   srdy rsp rdata         m0r m1r sv g m0p m1p err cnt
      // reset high: nothing granted, response ignored
      add(1, 1,0,32'h100,         1,0,32'h200,  1,1,32'h0,        0,0,0,0, 0,0,0,0);
      // contention writes: m0 first after reset, then alternate
      add(0, 1,1,32'h10,          1,1,32'h20,   1,0,32'h0,        1,0,1,0, 0,0,0,0);
      add(0, 1,1,32'h10,          1,1,32'h20,   1,0,32'h0,        0,1,1,1, 0,0,0,0);
      add(0, 1,1,32'h14,          1,1,32'h20,   1,0,32'h0,        1,0,1,0, 0,0,0,0);
      add(0, 0,0,32'h0,           1,1,32'h24,   1,0,32'h0,        0,1,1,1, 0,0,0,0);
      // single master read, answered two cycles later
      add(0, 1,0,32'h100,         0,0,32'h0,    1,0,32'h0,        1,0,1,0, 0,0,0,0);
      add(0, 0,0,32'h0,           0,0,32'h0,    1,0,32'h0,        0,0,0,0, 0,0,0,1);
      add(0, 0,0,32'h0,           0,0,32'h0,    0,1,32'hDEADBEEF, 0,0,0,0, 1,0,0,1);
      add(0, 0,0,32'h0,           0,0,32'h0,    0,0,32'h0,        0,0,0,0, 0,0,0,0);
      // interleaved reads A(m0) B(m1) C(m0), in-order responses
      add(0, 1,0,32'hA00,         0,0,32'h0,    1,0,32'h0,        1,0,1,0, 0,0,0,0);
      add(0, 0,0,32'h0,           1,0,32'hB00,  1,0,32'h0,        0,1,1,1, 0,0,0,1);
      add(0, 1,0,32'hC00,         0,0,32'h0,    1,0,32'h0,        1,0,1,0, 0,0,0,2);
      add(0, 0,0,32'h0,           0,0,32'h0,    0,1,32'h1,        0,0,0,0, 1,0,0,3);
      add(0, 0,0,32'h0,           0,0,32'h0,    0,1,32'h2,        0,0,0,0, 0,1,0,2);
      // push and pop in the same cycle: count holds
      add(0, 1,0,32'hD00,         0,0,32'h0,    1,1,32'h3,        1,0,1,0, 1,0,0,1);
      add(0, 0,0,32'h0,           0,0,32'h0,    0,1,32'h4,        0,0,0,0, 1,0,0,1);
      // unexpected response: dropped, error is sticky from next cycle
      add(0, 0,0,32'h0,           0,0,32'h0,    0,1,32'h5,        0,0,0,0, 0,0,0,0);
      add(0, 0,0,32'h0,           0,0,32'h0,    0,0,32'h0,        0,0,0,0, 0,0,1,0);
      // stall three cycles: grant stays on m1 (m0 won last)
      add(0, 1,0,32'hE00,         1,0,32'hF00,  0,0,32'h0,        0,0,1,1, 0,0,1,0);
      add(0, 1,0,32'hE00,         1,0,32'hF00,  0,0,32'h0,        0,0,1,1, 0,0,1,0);
      add(0, 1,0,32'hE00,         1,0,32'hF00,  0,0,32'h0,        0,0,1,1, 0,0,1,0);
      add(0, 1,0,32'hE00,         1,0,32'hF00,  1,0,32'h0,        0,1,1,1, 0,0,1,0);
      add(0, 1,0,32'hE00,         1,0,32'hF04,  1,0,32'h0,        1,0,1,0, 0,0,1,1);
      // reset with two reads outstanding, response during reset ignored
      add(1, 0,0,32'h0,           0,0,32'h0,    0,1,32'h1,        0,0,0,0, 0,0,1,2);
      add(0, 1,1,32'h30,          1,1,32'h40,   1,0,32'h0,        1,0,1,0, 0,0,0,0);
      // in-flight reads were discarded, so this response is unexpected
      add(0, 0,0,32'h0,           0,0,32'h0,    0,1,32'h9,        0,0,0,0, 0,0,0,0);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].rst, vq[i].m0_v, vq[i].m0_wr, vq[i].m0_a, vq[i].m1_v,
               vq[i].m1_wr, vq[i].m1_a, vq[i].s_rdy, vq[i].s_rsp, vq[i].s_rd);
         #2;
         check_vec(i, vq[i]);
      end

      @(negedge clk);
      #2;
      chk("err set after dropped rsp", 32'(err), 32'd1);

      // ---------- outstanding limit: slave withholds responses ----------
      @(negedge clk);
      drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < MAXO; i++) begin
         @(negedge clk);
         drive(1'b0, 0, 0, 0, 1, 0, 32'h400 + 32'(i * 4), 1, 0, 0);
         #2;
         chk($sformatf("lim read %0d m1_cmd_ready", i), 32'(m1_if.cmd_ready), 32'd1);
         chk($sformatf("lim read %0d count", i), 32'(dbg_count), 32'(i));
      end
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 1, 0, 32'h410, 1, 0, 0);
      #2;
      chk("lim 5th m1_cmd_ready", 32'(m1_if.cmd_ready), 32'd0);
      chk("lim 5th s_cmd_valid", 32'(s_if.cmd_valid), 32'd0);
      chk("lim full count", 32'(dbg_count), 32'(MAXO));
      // m0 write still passes while m1's read is held back
      @(negedge clk);
      drive(1'b0, 1, 1, 32'h50, 1, 0, 32'h410, 1, 0, 0);
      #2;
      chk("lim m0 write ready", 32'(m0_if.cmd_ready), 32'd1);
      chk("lim m0 write m1 ready", 32'(m1_if.cmd_ready), 32'd0);
      chk("lim m0 write addr", s_if.cmd_addr, 32'h50);
      // first response: no same-cycle release of the blocked read
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 1, 0, 32'h410, 1, 1, 32'h55);
      #2;
      chk("lim rsp cycle m1_cmd_ready", 32'(m1_if.cmd_ready), 32'd0);
      chk("lim rsp m1_rsp_ready", 32'(m1_if.rsp_ready), 32'd1);
      chk("lim rsp m0_rsp_ready", 32'(m0_if.rsp_ready), 32'd0);
      chk("lim rsp rdata", m1_if.rsp_rdata, 32'h55);
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 1, 0, 32'h410, 1, 0, 0);
      #2;
      chk("lim 5th accepted next cycle", 32'(m1_if.cmd_ready), 32'd1);
      chk("lim count after rsp", 32'(dbg_count), 32'(MAXO - 1));
      for (int i = 0; i < MAXO; i++) begin
         @(negedge clk);
         drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h60 + 32'(i));
         #2;
         chk($sformatf("drain %0d m1_rsp_ready", i), 32'(m1_if.rsp_ready), 32'd1);
         chk($sformatf("drain %0d rdata", i), m1_if.rsp_rdata, 32'h60 + 32'(i));
      end
      @(negedge clk);
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("drain count zero", 32'(dbg_count), 32'd0);
      chk("drain no error", 32'(err), 32'd0);

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
